ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin controller for the single-port, synchronous-write / combinational-read data RAM (bitsDirect address bits, sizeBitLine data bits).
- Serialises read/write transactions from two masters onto the RAM port, one transaction at a time.
- Sequences a full-memory zero-clear after reset and on command.
- Sits between the RAM instance and its two clients (e.g. datapath load/store unit and debug/loader port).

Parameters:
bitsDirect, 6, RAM address width; depth = 2**bitsDirect
sizeBitLine, 32, RAM data width

Ports:
clk  in  1  system clock, all state on rising edge
gen_reset_n  in  1  asynchronous active-low reset
clear_start  in  1  request full-memory zero-clear (sampled only in IDLE)
req0  in  1  requester 0 transaction request
we0  in  1  requester 0: 1=write, 0=read
addr0  in  bitsDirect  requester 0 address
wdata0  in  sizeBitLine  requester 0 write data
ack0  out  1  one-cycle completion pulse to requester 0
rdata0  out  sizeBitLine  requester 0 read data, valid with ack0, held until next ack0
req1/we1/addr1/wdata1/ack1/rdata1  same as requester 0, for requester 1
busy  out  1  high in any state other than IDLE
clear_done  out  1  one-cycle pulse after last clear write
ram_we  out  1  to RAM write_enable
ram_adress  out  bitsDirect  to RAM adress
ram_data_in  out  sizeBitLine  to RAM data_in
ram_data_out  in  sizeBitLine  from RAM data_out (combinational read)

Behaviour:
- States: CLEAR, IDLE, ACCESS, RESP. Reset state is CLEAR.
- Reset values: clear counter 0; last_grant=1 (requester 0 wins first tie); ack0/ack1/clear_done 0; rdata0/rdata1 0; latched addr/we/wdata 0.
- While gen_reset_n=0: ram_we forced 0 and busy=1.
- CLEAR:
  - Each cycle drives ram_we=1, ram_adress=counter, ram_data_in=0, then increments counter.
  - When counter = 2**bitsDirect-1, that write completes, clear_done pulses for exactly one cycle (the first IDLE cycle), counter wraps to 0, and the state goes to IDLE.
  - Clear takes exactly 2**bitsDirect cycles (64 at default).
  - req0/req1 and clear_start are ignored during CLEAR; no ack is issued.
- IDLE:
  - ram_we=0.
  - If clear_start=1: go to CLEAR. Clear takes priority over any pending req.
  - Else if any req:
    - Pick a winner. A single requester wins outright. If both request, the winner is the one not equal to last_grant.
    - Latch the winner's we/addr/wdata and the winner id, update last_grant, go to ACCESS.
  - Else stay in IDLE.
- ACCESS:
  - Drives ram_adress=latched addr, ram_we=latched we, ram_data_in=latched wdata.
  - At the clock edge, captures ram_data_out into the winner's rdata register. rdata is updated on writes too; its value then is the pre-write contents.
  - Next state is RESP.
- RESP:
  - ram_we=0.
  - ack of the winner =1 for this single cycle; the loser's ack stays 0.
  - Next state is IDLE.
- Latency: from req sampled in IDLE (cycle N) to ack in cycle N+2. Throughput is one transaction per 3 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack.
  - Deassert req in the cycle after ack unless issuing a new transaction; req high in IDLE is always a new request.
  - Requester inputs are sampled only in IDLE.
- A losing requester keeps req high and is granted in the next IDLE, giving strict alternation under continuous contention.
- ram_adress/ram_data_in are 0 in IDLE and RESP; ram_we is never high outside CLEAR and write-ACCESS.
- Asynchronous reset mid-transaction or mid-clear aborts immediately: no ack, no clear_done; the clear restarts from address 0 after release.
- Widths: addr/wdata pass through unchanged; the clear counter is bitsDirect bits and wraps naturally.

Test Plan:
- Reset release -> busy=1 for 64 cycles, ram_we=1 with ram_adress 0..63 and ram_data_in=0, clear_done pulses once, busy drops; all reads then return 0.
- req0 write addr=5 wdata=32'hDEADBEEF, then req0 read addr=5 -> each ack0 arrives 2 cycles after IDLE sample; second ack0 has rdata0=32'hDEADBEEF; ack1 stays 0.
- req0 and req1 both high on the same IDLE cycle after reset -> requester 0 acked first, requester 1 acked 3 cycles later; repeat both -> order alternates 0,1,0,1.
- Write addr=63 value 32'h1, then clear_start in IDLE with req1 also high -> CLEAR taken first (64 cycles), then req1 served; read addr=63 returns 0.
- gen_reset_n asserted during ACCESS of a write and during clear cycle 20 -> no ack, no clear_done, ram_we low during reset; after release the full 64-cycle clear restarts at address 0.
- clear_start pulsed during ACCESS/RESP -> ignored; no CLEAR entered and busy drops to 0 after RESP.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester, RAM-port and status signals of ram_arbiter
// slave is the arbiter's view; master is the clients/RAM side.
interface ram_arbiter_if #(
  parameter int bitsDirect  = 6,
  parameter int sizeBitLine = 32
);
  logic                   clear_start;

  logic                   req0;
  logic                   we0;
  logic [bitsDirect-1:0]  addr0;
  logic [sizeBitLine-1:0] wdata0;
  logic                   ack0;
  logic [sizeBitLine-1:0] rdata0;

  logic                   req1;
  logic                   we1;
  logic [bitsDirect-1:0]  addr1;
  logic [sizeBitLine-1:0] wdata1;
  logic                   ack1;
  logic [sizeBitLine-1:0] rdata1;

  logic                   busy;
  logic                   clear_done;

  logic                   ram_we;
  logic [bitsDirect-1:0]  ram_adress;
  logic [sizeBitLine-1:0] ram_data_in;
  logic [sizeBitLine-1:0] ram_data_out;

  modport slave (
    input  clear_start,
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1,
    output busy, clear_done,
    output ram_we, ram_adress, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output clear_start,
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1,
    input  busy, clear_done,
    input  ram_we, ram_adress, ram_data_in,
    output ram_data_out
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin RAM port arbiter with zero-clear sequencer
// One transaction per IDLE->ACCESS->RESP pass; CLEAR zero-fills the RAM after reset or on command.
module ram_arbiter #(
  parameter int bitsDirect  = 6,
  parameter int sizeBitLine = 32
) (
  input  logic          clk,
  input  logic          gen_reset_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [bitsDirect-1:0] LAST_ADDR = '1;
  localparam logic [bitsDirect-1:0] ONE_ADDR  = {{(bitsDirect-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_next;

  logic [bitsDirect-1:0]  r_cnt;
  logic                   r_last_grant;
  logic                   r_win;
  logic                   r_we;
  logic [bitsDirect-1:0]  r_addr;
  logic [sizeBitLine-1:0] r_wdata;
  logic                   r_ack0;
  logic                   r_ack1;
  logic                   r_clear_done;
  logic [sizeBitLine-1:0] r_rdata0;
  logic [sizeBitLine-1:0] r_rdata1;

  logic                   w_grant_valid;
  logic                   w_grant_id;
  logic                   w_ram_we;
  logic [bitsDirect-1:0]  w_ram_adress;
  logic [sizeBitLine-1:0] w_ram_data_in;

  // Under contention the requester not served last time wins; otherwise the sole requester.
  always_comb begin
    w_grant_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = bus.req1;
    end
  end

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_ram_we      = 1'b0;
    w_ram_adress  = '0;
    w_ram_data_in = '0;
    case (r_state)
      S_CLEAR: begin
        w_ram_we     = 1'b1;
        w_ram_adress = r_cnt;
        if (r_cnt == LAST_ADDR) begin
          w_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.clear_start) begin
          w_next = S_CLEAR;
        end else if (w_grant_valid) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_ram_we      = r_we;
        w_ram_adress  = r_addr;
        w_ram_data_in = r_wdata;
        w_next        = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_win        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_clear_done <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_clear_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + ONE_ADDR;
          if (r_cnt == LAST_ADDR) begin
            r_clear_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!bus.clear_start && w_grant_valid) begin
            r_win        <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_we         <= w_grant_id ? bus.we1    : bus.we0;
            r_addr       <= w_grant_id ? bus.addr1  : bus.addr0;
            r_wdata      <= w_grant_id ? bus.wdata1 : bus.wdata0;
          end
        end
        S_ACCESS: begin
          // The read port is combinational, so on a write this captures the old contents.
          if (r_win) begin
            r_rdata1 <= bus.ram_data_out;
            r_ack1   <= 1'b1;
          end else begin
            r_rdata0 <= bus.ram_data_out;
            r_ack0   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The write strobe is gated by reset so an aborted clear or write never lands.
  assign bus.ram_we      = w_ram_we & gen_reset_n;
  assign bus.ram_adress  = w_ram_adress;
  assign bus.ram_data_in = w_ram_data_in;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.clear_done  = r_clear_done;
  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.rdata0      = r_rdata0;
  assign bus.rdata1      = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a transaction-level model
module tb_ram_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic gen_reset_n = 1'b1;

  ram_arbiter_if #(.bitsDirect(AW), .sizeBitLine(DW)) bus ();

  ram_arbiter #(.bitsDirect(AW), .sizeBitLine(DW)) dut (
    .clk         (clk),
    .gen_reset_n (gen_reset_n),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_adress] <= bus.ram_data_in;
  end
  assign bus.ram_data_out = mem[bus.ram_adress];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: clear as a countdown of remaining writes, a transaction as a phase counter.
  int            m_clr;
  int            m_ph;
  logic          m_w, m_we, m_last, m_cd;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rd0, m_rd1;
  logic [DW-1:0] m_mem [DEPTH];

  always @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      m_clr  <= DEPTH;
      m_ph   <= 0;
      m_last <= 1'b1;
      m_cd   <= 1'b0;
      m_rd0  <= '0;
      m_rd1  <= '0;
      m_w    <= 1'b0;
      m_we   <= 1'b0;
      m_a    <= '0;
      m_d    <= '0;
    end else begin
      m_cd <= 1'b0;
      if (m_clr > 0) begin
        m_mem[DEPTH - m_clr] <= '0;
        m_clr <= m_clr - 1;
        if (m_clr == 1) m_cd <= 1'b1;
      end else if (m_ph == 1) begin
        if (m_w) m_rd1 <= m_mem[m_a];
        else     m_rd0 <= m_mem[m_a];
        if (m_we) m_mem[m_a] <= m_d;
        m_ph <= 2;
      end else if (m_ph == 2) begin
        m_ph <= 0;
      end else if (bus.clear_start) begin
        m_clr <= DEPTH;
      end else if (bus.req0 && !bus.req1) begin
        m_w <= 1'b0; m_last <= 1'b0; m_we <= bus.we0; m_a <= bus.addr0; m_d <= bus.wdata0; m_ph <= 1;
      end else if (bus.req1 && !bus.req0) begin
        m_w <= 1'b1; m_last <= 1'b1; m_we <= bus.we1; m_a <= bus.addr1; m_d <= bus.wdata1; m_ph <= 1;
      end else if (bus.req0 && bus.req1 && m_last) begin
        m_w <= 1'b0; m_last <= 1'b0; m_we <= bus.we0; m_a <= bus.addr0; m_d <= bus.wdata0; m_ph <= 1;
      end else if (bus.req0 && bus.req1) begin
        m_w <= 1'b1; m_last <= 1'b1; m_we <= bus.we1; m_a <= bus.addr1; m_d <= bus.wdata1; m_ph <= 1;
      end
    end
  end

  task automatic check_outputs();
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    e_we   = gen_reset_n && ((m_clr > 0) || (m_ph == 1 && m_we));
    e_addr = (m_clr > 0) ? AW'(DEPTH - m_clr) : ((m_ph == 1) ? m_a : '0);
    e_din  = (m_clr == 0 && m_ph == 1) ? m_d : '0;
    chk("ram_we",      32'(bus.ram_we),      32'(e_we));
    chk("ram_adress",  32'(bus.ram_adress),  32'(e_addr));
    chk("ram_data_in", bus.ram_data_in,      e_din);
    chk("busy",        32'(bus.busy),        32'(!(m_clr == 0 && m_ph == 0)));
    chk("clear_done",  32'(bus.clear_done),  32'(m_cd));
    chk("ack0",        32'(bus.ack0),        32'(m_clr == 0 && m_ph == 2 && !m_w));
    chk("ack1",        32'(bus.ack1),        32'(m_clr == 0 && m_ph == 2 && m_w));
    chk("rdata0",      bus.rdata0,           m_rd0);
    chk("rdata1",      bus.rdata1,           m_rd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) check_outputs();
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_clear(output int writes, output int pulses);
    writes = 0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.clear_done) begin
        pulses = 1;
        break;
      end
      if (bus.ram_we) writes++;
      step();
    end
  endtask

  task automatic do_txn(input bit id, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output int lat, output logic [DW-1:0] rd);
    lat = -1;
    rd  = 'x;
    if (id) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data; end
    else    begin bus.req0 = 1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data; end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (id ? bus.ack1 : bus.ack0) begin
        lat = k;
        rd  = id ? bus.rdata1 : bus.rdata0;
        break;
      end
    end
    bus.req0 = 0;
    bus.req1 = 0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            w, p, lat, k, r0, r1;
    logic [DW-1:0] rd;
    int            ord[$];
    int            cyc[$];
    logic [DW-1:0] rds[$];

    bus.clear_start = 0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    #1 gen_reset_n = 0;
    step();
    chk_en = 1;
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    step();

    // Power-up clear
    gen_reset_n = 1;
    #1;
    wait_clear(w, p);
    chk("clear_writes", 32'(w), 32'd64);
    chk("clear_done_seen", 32'(p), 32'd1);
    chk("busy_after_clear", 32'(bus.busy), 32'd0);
    step();
    chk("clear_done_once", 32'(bus.clear_done), 32'd0);

    do_txn(0, 0, 6'd10, '0, lat, rd);
    chk("rd10_lat", 32'(lat), 32'd2);
    chk("rd10_zero", rd, 32'd0);

    // Write then read back on requester 0
    do_txn(0, 1, 6'd5, 32'hDEADBEEF, lat, rd);
    chk("wr5_lat", 32'(lat), 32'd2);
    chk("wr5_prewrite", rd, 32'd0);
    do_txn(0, 0, 6'd5, '0, lat, rd);
    chk("rd5_lat", 32'(lat), 32'd2);
    chk("rd5_data", rd, 32'hDEADBEEF);

    // Clear beats a simultaneous request
    do_txn(1, 1, 6'd63, 32'h1, lat, rd);
    chk("wr63_lat", 32'(lat), 32'd2);
    bus.clear_start = 1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 6'd63;
    p = 0;
    lat = -1;
    for (k = 1; k <= 200; k++) begin
      step();
      bus.clear_start = 0;
      if (bus.clear_done) p++;
      if (bus.ack1) begin lat = k; rd = bus.rdata1; break; end
    end
    bus.req1 = 0;
    step();
    chk("clear_then_req1_lat", 32'(lat), 32'd67);
    chk("clear_then_req1_pulse", 32'(p), 32'd1);
    chk("rd63_after_clear", rd, 32'd0);
    do_txn(0, 0, 6'd5, '0, lat, rd);
    chk("rd5_after_clear", rd, 32'd0);

    // clear_start outside IDLE is ignored
    do_txn(0, 1, 6'd9, 32'hCAFE0009, lat, rd);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6'd9;
    step();
    bus.clear_start = 1;
    step();
    chk("ign_ack0", 32'(bus.ack0), 32'd1);
    chk("ign_rdata0", bus.rdata0, 32'hCAFE0009);
    bus.clear_start = 0;
    bus.req0 = 0;
    step();
    chk("ign_busy_idle", 32'(bus.busy), 32'd0);
    step();
    chk("ign_busy_idle2", 32'(bus.busy), 32'd0);

    // Reset during a write ACCESS
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd7; bus.wdata0 = 32'h55;
    step();
    chk("acc_we", 32'(bus.ram_we), 32'd1);
    gen_reset_n = 0;
    #1;
    chk("rst_acc_we", 32'(bus.ram_we), 32'd0);
    chk("rst_acc_busy", 32'(bus.busy), 32'd1);
    step();
    chk("rst_acc_noack", 32'(bus.ack0), 32'd0);
    bus.req0 = 0;
    step();
    gen_reset_n = 1;
    #1;
    chk("restart_addr0", 32'(bus.ram_adress), 32'd0);
    chk("restart_we", 32'(bus.ram_we), 32'd1);
    p = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.clear_done) p++;
    end
    chk("mid_clear_addr", 32'(bus.ram_adress), 32'd20);
    gen_reset_n = 0;
    #1;
    chk("rst_clear_we", 32'(bus.ram_we), 32'd0);
    step();
    if (bus.clear_done) p++;
    chk("no_clear_done_abort", 32'(p), 32'd0);
    step();
    gen_reset_n = 1;
    #1;
    chk("restart2_addr0", 32'(bus.ram_adress), 32'd0);
    wait_clear(w, p);
    chk("clear2_writes", 32'(w), 32'd64);
    chk("clear2_done", 32'(p), 32'd1);
    step();

    // Contention: strict alternation starting with requester 0
    r0 = 2; r1 = 2;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6'd2;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 6'd2; bus.wdata1 = 32'hA5A5;
    for (k = 1; k <= 40 && (r0 > 0 || r1 > 0); k++) begin
      step();
      if (bus.ack0) begin
        ord.push_back(0); cyc.push_back(k); rds.push_back(bus.rdata0);
        r0--;
        if (r0 == 0) bus.req0 = 0;
      end
      if (bus.ack1) begin
        ord.push_back(1); cyc.push_back(k); rds.push_back(bus.rdata1);
        r1--;
        if (r1 == 0) bus.req1 = 0;
        bus.wdata1 = 32'h5A5A;
      end
    end
    bus.req0 = 0;
    bus.req1 = 0;
    step();
    chk("cont_count", 32'(ord.size()), 32'd4);
    if (ord.size() == 4) begin
      chk("cont_ord0", 32'(ord[0]), 32'd0);
      chk("cont_ord1", 32'(ord[1]), 32'd1);
      chk("cont_ord2", 32'(ord[2]), 32'd0);
      chk("cont_ord3", 32'(ord[3]), 32'd1);
      chk("cont_cyc0", 32'(cyc[0]), 32'd2);
      chk("cont_cyc1", 32'(cyc[1]), 32'd5);
      chk("cont_cyc2", 32'(cyc[2]), 32'd8);
      chk("cont_cyc3", 32'(cyc[3]), 32'd11);
      chk("cont_rd0", rds[0], 32'd0);
      chk("cont_rd1", rds[1], 32'd0);
      chk("cont_rd2", rds[2], 32'hA5A5);
      chk("cont_rd3", rds[3], 32'hA5A5);
    end
    step();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
